// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings, latency defaults, FSM states.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result generator for mult/div (and madd/maddu when MDU_MADD_EN is defined).
// wr_o is low when the operation must leave HI/LO untouched (divide by zero, non-arith ops).
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        wr_o
);

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

    logic signed [31:0] a_s, b_s;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_nz, q_u, r_u, mag_a, mag_b, q_m, r_m, q_s, r_s;

    assign a_s    = a_i;
    assign b_s    = b_i;
    assign prod_s = 64'(a_s) * 64'(b_s);
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Divisor forced non-zero so the dividers never see 0; the result is discarded via wr_o.
    assign b_nz  = (b_i == 32'd0) ? 32'd1 : b_i;
    assign q_u   = a_i / b_nz;
    assign r_u   = a_i % b_nz;
    assign mag_a = abs32(a_i);
    assign mag_b = abs32(b_nz);
    assign q_m   = mag_a / mag_b;
    assign r_m   = mag_a % mag_b;
    assign q_s   = (a_i[31] ^ b_nz[31]) ? neg32(q_m) : q_m;
    assign r_s   = a_i[31] ? neg32(r_m) : r_m;

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_i, lo_i};
`endif

    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        wr_o = 1'b0;
        case (op_i)
            OP_MULT: begin
                {hi_o, lo_o} = $unsigned(prod_s);
                wr_o = 1'b1;
            end
            OP_MULTU: begin
                {hi_o, lo_o} = prod_u;
                wr_o = 1'b1;
            end
            OP_DIV: begin
                hi_o = r_s;
                lo_o = q_s;
                wr_o = (b_i != 32'd0);
            end
            OP_DIVU: begin
                hi_o = r_u;
                lo_o = q_u;
                wr_o = (b_i != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                {hi_o, lo_o} = acc + $unsigned(prod_s);
                wr_o = 1'b1;
            end
            OP_MADDU: begin
                {hi_o, lo_o} = acc + prod_u;
                wr_o = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; latency modelled by a down-counter.
// Optional MDU_MADD_EN enables madd/maddu (accumulate into {HI,LO}).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] MDOut
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] calc_hi, calc_lo;
    logic        calc_wr, is_mul, is_div, launch;

    mdu_calc u_calc (
        .op_i (MDOp),
        .a_i  (A),
        .b_i  (B),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .hi_o (calc_hi),
        .lo_o (calc_lo),
        .wr_o (calc_wr)
    );

    always_comb begin
        is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (MDOp == OP_MADD) || (MDOp == OP_MADDU);
`endif
        is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
        launch = Start && (is_mul || is_div);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d   = RUN;
                    cnt_d     = is_div ? DIV_LD : MULT_LD;
                    pend_hi_d = calc_hi;
                    pend_lo_d = calc_lo;
                    pend_wr_d = calc_wr;
                end else if (MDOp == OP_MTHI) begin
                    hi_d = A;
                end else if (MDOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                // Start and MTHI/MTLO are deliberately ignored while an operation is in flight.
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy = (state_q == RUN);

    always_comb begin
        case (MDOp)
            OP_MFHI: MDOut = hi_q;
            OP_MFLO: MDOut = lo_q;
            default: MDOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver queues expected Busy/MDOut values per cycle,
// a negedge monitor pops and compares them.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  MDOp = OP_NONE;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic [31:0] MDOut;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .MDOut (MDOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_busy;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb[$];
    chk_t        mc;
    int          obs_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] act;

    always @(negedge clk) begin
        for (int i = 0; i < obs_cnt; i++) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                mc  = sb.pop_front();
                act = mc.is_busy ? {31'd0, Busy} : MDOut;
                if (act !== mc.exp) begin
                    failures++;
                    $display("FAIL %s actual=0x%08h required=0x%08h", mc.name, act, mc.exp);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        reset   = rst;
        Start   = st;
        MDOp    = op;
        A       = a;
        B       = b;
        obs_cnt = 0;
    endtask

    task automatic exp_busy(input string n, input logic e);
        sb.push_back('{name: n, is_busy: 1'b1, exp: {31'd0, e}});
        obs_cnt++;
    endtask

    task automatic exp_out(input string n, input logic [31:0] e);
        sb.push_back('{name: n, is_busy: 1'b0, exp: e});
        obs_cnt++;
    endtask

    task automatic read_hilo(input string n, input logic [31:0] hi, input logic [31:0] lo);
        cyc(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0);
        exp_busy({n, "_busy_done"}, 1'b0);
        exp_out({n, "_hi"}, hi);
        cyc(1'b0, 1'b0, OP_MFLO, 32'd0, 32'd0);
        exp_out({n, "_lo"}, lo);
    endtask

    // Launch op, then hold mop/ma/mst for 'cycles' cycles expecting Busy==eb each cycle.
    task automatic run_op(input string n, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles, input logic eb,
                          input logic [3:0] mop, input logic [31:0] ma, input logic mst);
        cyc(1'b0, 1'b1, op, a, b);
        exp_busy({n, "_launch"}, 1'b0);
        for (int i = 0; i < cycles; i++) begin
            cyc(1'b0, mst, mop, ma, ma);
            exp_busy({n, "_busy"}, eb);
        end
    endtask

    task automatic mt(input logic [31:0] hi, input logic [31:0] lo);
        cyc(1'b0, 1'b0, OP_MTHI, hi, 32'd0);
        cyc(1'b0, 1'b0, OP_MTLO, lo, 32'd0);
    endtask

    initial begin
        cyc(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0);
        cyc(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0);
        read_hilo("reset", 32'h0, 32'h0);

        run_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3, 5, 1'b1, OP_NONE, 32'd0, 1'b0);
        read_hilo("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA);

        run_op("divu", OP_DIVU, 32'd100, 32'd7, 10, 1'b1, OP_NONE, 32'd0, 1'b0);
        read_hilo("divu", 32'd2, 32'd14);

        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 1'b1, OP_NONE, 32'd0, 1'b0);
        read_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);

        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 1'b1, OP_NONE, 32'd0, 1'b0);
        read_hilo("div_ovf", 32'h0, 32'h80000000);

        cyc(1'b0, 1'b0, OP_MTLO, 32'h1234, 32'd0);
        exp_out("mtlo_out_zero", 32'h0);
        cyc(1'b0, 1'b0, OP_MFLO, 32'd0, 32'd0);
        exp_out("mtlo_read", 32'h1234);
        cyc(1'b0, 1'b0, OP_MTHI, 32'hABCD, 32'd0);
        cyc(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0);
        exp_out("mthi_read", 32'hABCD);

        run_op("multu_mthi", OP_MULTU, 32'h10000, 32'h10000, 5, 1'b1, OP_MTHI, 32'hDEAD, 1'b0);
        read_hilo("multu_mthi", 32'h1, 32'h0);

        run_op("start_in_run", OP_MULT, 32'd2, 32'd3, 5, 1'b1, OP_DIVU, 32'd5, 1'b1);
        read_hilo("start_in_run", 32'h0, 32'h6);

        mt(32'd5, 32'd6);
        run_op("div_zero", OP_DIV, 32'd9, 32'd0, 10, 1'b1, OP_NONE, 32'd0, 1'b0);
        read_hilo("div_zero", 32'd5, 32'd6);
        run_op("divu_zero", OP_DIVU, 32'd9, 32'd0, 10, 1'b1, OP_NONE, 32'd0, 1'b0);
        read_hilo("divu_zero", 32'd5, 32'd6);

        run_op("rst_mid", OP_MULT, 32'd7, 32'd9, 2, 1'b1, OP_NONE, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0);
        exp_busy("rst_mid_T3_busy", 1'b1);
        read_hilo("rst_mid", 32'h0, 32'h0);
        run_op("after_rst", OP_MULT, 32'd7, 32'd9, 5, 1'b1, OP_NONE, 32'd0, 1'b0);
        read_hilo("after_rst", 32'h0, 32'd63);

        cyc(1'b0, 1'b1, 4'd11, 32'd4, 32'd4);
        exp_out("op11_out", 32'h0);
        cyc(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0);
        exp_busy("op11_no_launch", 1'b0);
        read_hilo("op11", 32'h0, 32'd63);

        mt(32'h0, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, 1'b1, OP_NONE, 32'd0, 1'b0);
        read_hilo("maddu", 32'h1, 32'h0);
        mt(32'h0, 32'd5);
        run_op("madd", OP_MADD, 32'hFFFFFFFE, 32'd3, 5, 1'b1, OP_NONE, 32'd0, 1'b0);
        read_hilo("madd", 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
        run_op("maddu_off", OP_MADDU, 32'd1, 32'd1, 5, 1'b0, OP_NONE, 32'd0, 1'b0);
        read_hilo("maddu_off", 32'h0, 32'hFFFFFFFF);
        mt(32'h0, 32'd5);
        run_op("madd_off", OP_MADD, 32'hFFFFFFFE, 32'd3, 5, 1'b0, OP_NONE, 32'd0, 1'b0);
        read_hilo("madd_off", 32'h0, 32'd5);
`endif

        cyc(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
